// File: rtl/pipe_stage_reg_if.sv
// Payload/valid bundle between two pipeline stages around a pipe_stage_reg.
// master drives the upstream side and observes the registered side; slave is the register.
interface pipe_stage_reg_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic [W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with flush, bubble masking and
// saturating stall/bubble/flush performance counters.
module pipe_stage_reg #(
    parameter int             W            = 32,
    parameter int             STALL_W      = 6,
    parameter int             STAGE        = 4,
    parameter logic [W-1:0]   BUBBLE_MASK  = {W{1'b1}},
    parameter bit             ZERO_INVALID = 1'b1,
    parameter int             CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    pipe_stage_reg_if.slave    bus,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [1:0] ACT_FLUSH   = 2'd0;
    localparam logic [1:0] ACT_ADVANCE = 2'd1;
    localparam logic [1:0] ACT_BUBBLE  = 2'd2;
    localparam logic [1:0] ACT_HOLD    = 2'd3;

    localparam bit HAS_DOWN = (STAGE < STALL_W - 1);
    localparam int DOWN_IDX = HAS_DOWN ? STAGE + 1 : STAGE;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic         stall_here;
    logic         stall_down;
    logic [1:0]   action;
    logic [W-1:0] cleared_data;
    logic         unused_stall_bits;

    assign stall_here        = stall[STAGE];
    assign stall_down        = HAS_DOWN ? stall[DOWN_IDX] : 1'b0;
    assign cleared_data      = bus.out_data & ~BUBBLE_MASK;
    assign unused_stall_bits = ^stall;

    always_comb begin
        action = ACT_HOLD;
        if (flush)
            action = ACT_FLUSH;
        else if (!stall_here)
            action = ACT_ADVANCE;
        else if (!stall_down)
            action = ACT_BUBBLE;
        else
            action = ACT_HOLD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            case (action)
                ACT_FLUSH, ACT_BUBBLE: begin
                    bus.out_valid <= 1'b0;
                    bus.out_data  <= cleared_data;
                end
                ACT_ADVANCE: begin
                    bus.out_valid <= bus.in_valid;
                    if (!bus.in_valid && ZERO_INVALID)
                        bus.out_data <= cleared_data;
                    else
                        bus.out_data <= bus.in_data;
                end
                default: begin
                    bus.out_valid <= bus.out_valid;
                    bus.out_data  <= bus.out_data;
                end
            endcase
        end
    end

    // Counters only observe the chosen action; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (action == ACT_HOLD && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (action == ACT_BUBBLE && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_ONE;
            if (action == ACT_FLUSH && bus.out_valid && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations share one stimulus stream and
// are checked every cycle against a behavioural model, plus literal pins.
module tb_pipe_stage_reg;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] stall = '0;
    logic       flush = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.W(8)) bus0 ();
    pipe_stage_reg_if #(.W(8)) bus1 ();
    pipe_stage_reg_if #(.W(8)) bus2 ();

    assign bus0.in_valid = in_valid;
    assign bus0.in_data  = in_data;
    assign bus1.in_valid = in_valid;
    assign bus1.in_data  = in_data;
    assign bus2.in_valid = in_valid;
    assign bus2.in_data  = in_data;

    logic [15:0] s_cnt0, b_cnt0, f_cnt0;
    logic [2:0]  s_cnt1, b_cnt1, f_cnt1;
    logic [2:0]  s_cnt2, b_cnt2, f_cnt2;

    pipe_stage_reg #(.W(8), .STALL_W(6), .STAGE(4), .BUBBLE_MASK(8'hFF),
                     .ZERO_INVALID(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .bus(bus0.slave), .stall_cnt(s_cnt0), .bubble_cnt(b_cnt0), .flush_cnt(f_cnt0));

    pipe_stage_reg #(.W(8), .STALL_W(6), .STAGE(4), .BUBBLE_MASK(8'h0F),
                     .ZERO_INVALID(1'b0), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .bus(bus1.slave), .stall_cnt(s_cnt1), .bubble_cnt(b_cnt1), .flush_cnt(f_cnt1));

    pipe_stage_reg #(.W(8), .STALL_W(6), .STAGE(5), .BUBBLE_MASK(8'hFF),
                     .ZERO_INVALID(1'b1), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .bus(bus2.slave), .stall_cnt(s_cnt2), .bubble_cnt(b_cnt2), .flush_cnt(f_cnt2));

    int         cfg_stage [N] = '{4, 4, 5};
    logic [7:0] cfg_mask  [N] = '{8'hFF, 8'h0F, 8'hFF};
    bit         cfg_zi    [N] = '{1'b1, 1'b0, 1'b1};
    int         cfg_max   [N] = '{65535, 7, 7};

    bit         m_valid [N];
    logic [7:0] m_data  [N];
    int         m_cnt   [N][3];

    int  n_checks = 0;
    int  n_fail = 0;
    bit  check_en = 1'b0;

    string field_name [5] = '{"valid", "data", "stall_cnt", "bubble_cnt", "flush_cnt"};

    function automatic int dut_val(input int k, input int f);
        case (k)
            0: case (f)
                   0: return int'(bus0.out_valid);
                   1: return int'(bus0.out_data);
                   2: return int'(s_cnt0);
                   3: return int'(b_cnt0);
                   default: return int'(f_cnt0);
               endcase
            1: case (f)
                   0: return int'(bus1.out_valid);
                   1: return int'(bus1.out_data);
                   2: return int'(s_cnt1);
                   3: return int'(b_cnt1);
                   default: return int'(f_cnt1);
               endcase
            default: case (f)
                   0: return int'(bus2.out_valid);
                   1: return int'(bus2.out_data);
                   2: return int'(s_cnt2);
                   3: return int'(b_cnt2);
                   default: return int'(f_cnt2);
               endcase
        endcase
    endfunction

    function automatic int model_val(input int k, input int f);
        case (f)
            0: return int'(m_valid[k]);
            1: return int'(m_data[k]);
            default: return m_cnt[k][f-2];
        endcase
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Pins both the DUT and the model to a hand-derived value.
    task automatic check_lit(input int k, input int f, input int expected);
        check_output($sformatf("lit dut%0d.%s", k, field_name[f]), dut_val(k, f), expected);
        check_output($sformatf("lit model%0d.%s", k, field_name[f]), model_val(k, f), expected);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
        end
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            int  st   = cfg_stage[k];
            bit  here = stall[st];
            bit  down = (st == 5) ? 1'b0 : stall[st+1];
            logic [7:0] cleared = m_data[k] & ~cfg_mask[k];
            if (flush) begin
                if (m_valid[k]) m_cnt[k][2] = sat_inc(m_cnt[k][2], cfg_max[k]);
                m_valid[k] = 1'b0;
                m_data[k]  = cleared;
            end else if (!here) begin
                m_data[k]  = (!in_valid && cfg_zi[k]) ? cleared : in_data;
                m_valid[k] = in_valid;
            end else if (!down) begin
                m_cnt[k][1] = sat_inc(m_cnt[k][1], cfg_max[k]);
                m_valid[k]  = 1'b0;
                m_data[k]   = cleared;
            end else begin
                m_cnt[k][0] = sat_inc(m_cnt[k][0], cfg_max[k]);
            end
            if (cnt_clr)
                for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic apply_stimulus(input logic [5:0] s, input logic f, input logic clr,
                                  input logic v, input logic [7:0] d);
        stall    = s;
        flush    = f;
        cnt_clr  = clr;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (check_en)
            for (int k = 0; k < N; k++)
                for (int f = 0; f < 5; f++)
                    check_output($sformatf("cmp dut%0d.%s", k, field_name[f]),
                                 dut_val(k, f), model_val(k, f));
    end

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check_lit(k, 0, 0);
            check_lit(k, 1, 0);
        end
        rst = 1'b1;
        check_en = 1'b1;

        apply_stimulus(6'b000000, 0, 0, 1, 8'h11);
        check_lit(0, 1, 8'h11);
        check_lit(0, 0, 1);

        repeat (3) apply_stimulus(6'b110000, 0, 0, 1, 8'h11);
        check_lit(0, 1, 8'h11);
        check_lit(0, 2, 3);
        check_lit(2, 3, 3);
        check_lit(2, 2, 0);
        check_lit(2, 0, 0);

        apply_stimulus(6'b010000, 0, 0, 1, 8'h22);
        check_lit(0, 1, 8'h00);
        check_lit(0, 0, 0);
        check_lit(0, 3, 1);

        apply_stimulus(6'b000000, 0, 0, 1, 8'h22);
        check_lit(0, 1, 8'h22);

        apply_stimulus(6'b000000, 0, 0, 1, 8'hAB);
        apply_stimulus(6'b010000, 0, 0, 1, 8'hAB);
        check_lit(1, 1, 8'hA0);
        check_lit(1, 0, 0);

        apply_stimulus(6'b000000, 0, 0, 1, 8'h77);
        apply_stimulus(6'b110000, 1, 0, 1, 8'h77);
        check_lit(0, 0, 0);
        check_lit(0, 1, 8'h00);
        check_lit(0, 4, 1);
        check_lit(0, 2, 3);
        apply_stimulus(6'b110000, 1, 0, 1, 8'h77);
        check_lit(0, 4, 1);

        apply_stimulus(6'b000000, 0, 0, 1, 8'h5A);
        apply_stimulus(6'b000000, 0, 0, 0, 8'hFF);
        check_lit(0, 1, 8'h00);
        check_lit(1, 1, 8'hFF);
        check_lit(1, 0, 0);

        repeat (10) apply_stimulus(6'b110000, 0, 0, 1, 8'h33);
        check_lit(1, 2, 7);
        check_lit(0, 2, 13);
        apply_stimulus(6'b110000, 0, 1, 1, 8'h33);
        check_lit(1, 2, 0);
        apply_stimulus(6'b110000, 0, 0, 1, 8'h33);
        check_lit(1, 2, 1);

        // Asynchronous reset asserted and released between clock edges.
        apply_stimulus(6'b000000, 0, 0, 1, 8'hA5);
        check_lit(0, 1, 8'hA5);
        check_lit(0, 0, 1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        for (int f = 0; f < 5; f++) check_lit(0, f, 0);
        #1 rst = 1'b1;
        apply_stimulus(6'b000000, 0, 0, 1, 8'h3C);
        check_lit(0, 1, 8'h3C);
        check_lit(0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] s;
            s = 6'($urandom);
            if ($urandom_range(0, 3) == 0) s[5:4] = 2'b11;
            apply_stimulus(s,
                           1'($urandom_range(0, 9) == 0),
                           1'($urandom_range(0, 24) == 0),
                           1'($urandom),
                           8'($urandom));
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
